// File: rtl/fsm_pkg.sv
// Shared definitions for the flow-control status interface: lane count,
// default thresholds and the per-lane flow-state encoding.
package fsm_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_AW    = 3;
  localparam int unsigned DEF_HIGH  = 6;
  localparam int unsigned DEF_LOW   = 2;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PAUSE_REQ = 2'd1,
    PAUSED    = 2'd2,
    CONT_REQ  = 2'd3
  } flow_state_e;

endpackage

// File: rtl/fifo_lane_status.sv
// One FIFO lane: saturating occupancy counter, sticky error flags and the
// pause/continue request FSM handshaking with the flow-control FSM.
module fifo_lane_status
  import fsm_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        push,
  input  logic        pop,
  input  logic        ack_pause,
  input  logic        ack_continue,
  input  logic [AW:0] high_thr,
  input  logic [AW:0] low_thr,
  output logic [AW:0] count,
  output logic        empty,
  output logic        full,
  output logic        pause,
  output logic        cont,
  output logic        overflow,
  output logic        underflow
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic        push_ok;
  logic        pop_ok;
  logic [AW:0] count_nxt;
  flow_state_e state;
  flow_state_e state_nxt;
  logic        pause_nxt;
  logic        cont_nxt;

  // Accepted push/pop and next count; init wins over traffic
  always_comb begin
    push_ok   = push && (count != FULL_CNT);
    pop_ok    = pop && (count != '0);
    count_nxt = count;
    if (init) begin
      count_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Empty/full are derived from the next count so they track count exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == FULL_CNT);
      overflow  <= init ? 1'b0 : (overflow  | (push && (count == FULL_CNT)));
      underflow <= init ? 1'b0 : (underflow | (pop && (count == '0)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pause <= 1'b0;
      cont  <= 1'b0;
    end else begin
      state <= state_nxt;
      pause <= pause_nxt;
      cont  <= cont_nxt;
    end
  end

  // Transitions look at the registered count, so requests lag count by a cycle
  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:       if (count >= high_thr) state_nxt = PAUSE_REQ;
        PAUSE_REQ: if (ack_pause)         state_nxt = PAUSED;
        PAUSED:    if (count <= low_thr)  state_nxt = CONT_REQ;
        CONT_REQ:  if (ack_continue)      state_nxt = RUN;
        default:                          state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    pause_nxt = 1'b0;
    cont_nxt  = 1'b0;
    pause_nxt = (state_nxt == PAUSE_REQ);
    cont_nxt  = (state_nxt == CONT_REQ);
  end

endmodule

// File: rtl/fifo_status_gen.sv
// FIFO-bank status generator: threshold registers with legality check,
// config-error flag, and LANES per-lane status trackers with packed outputs.
module fifo_status_gen
  import fsm_pkg::*;
#(
  parameter int unsigned LANES    = NUM_LANES,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned HIGH_DEF = DEF_HIGH,
  parameter int unsigned LOW_DEF  = DEF_LOW
) (
  input  logic                    CLK,
  input  logic                    sReset,
  input  logic                    iInit,
  input  logic [AW:0]             iHigh,
  input  logic [AW:0]             iLow,
  input  logic [LANES-1:0]        iPush,
  input  logic [LANES-1:0]        iPop,
  input  logic [LANES-1:0]        iAckPause,
  input  logic [LANES-1:0]        iAckContinue,
  output logic [LANES-1:0]        sEmpty,
  output logic [LANES-1:0]        sFull,
  output logic [LANES-1:0]        sPause,
  output logic [LANES-1:0]        sContinue,
  output logic [LANES*(AW+1)-1:0] oCount,
  output logic [LANES-1:0]        oOverflow,
  output logic [LANES-1:0]        oUnderflow,
  output logic                    oCfgErr
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] DEPTH_CNT = CW'(DEPTH);

  logic [AW:0] high_thr;
  logic [AW:0] low_thr;
  logic        cfg_legal_c;

  assign cfg_legal_c = (iLow < iHigh) && (iHigh <= DEPTH_CNT);

  // Illegal thresholds are rejected whole; the previous pair stays in force
  always_ff @(posedge CLK or negedge sReset) begin
    if (!sReset) begin
      high_thr <= CW'(HIGH_DEF);
      low_thr  <= CW'(LOW_DEF);
      oCfgErr  <= 1'b0;
    end else if (iInit) begin
      if (cfg_legal_c) begin
        high_thr <= iHigh;
        low_thr  <= iLow;
        oCfgErr  <= 1'b0;
      end else begin
        oCfgErr  <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fifo_lane_status #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_lane (
      .clk          (CLK),
      .rst_n        (sReset),
      .init         (iInit),
      .push         (iPush[g]),
      .pop          (iPop[g]),
      .ack_pause    (iAckPause[g]),
      .ack_continue (iAckContinue[g]),
      .high_thr     (high_thr),
      .low_thr      (low_thr),
      .count        (oCount[g*CW +: CW]),
      .empty        (sEmpty[g]),
      .full         (sFull[g]),
      .pause        (sPause[g]),
      .cont         (sContinue[g]),
      .overflow     (oOverflow[g]),
      .underflow    (oUnderflow[g])
    );
  end

endmodule
